shifter_seq: RTL and testbench
==============================

SHIFTER_SEQ -- requirements
Module: shifter_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a shift operation.
REQ-005 SHALL have port src, input, WIDTH bits: operand to shift.
REQ-006 SHALL have port shiftDirection, input, WIDTH bits: signed two's-complement amount; positive = left, negative = right, zero = pass-through.
REQ-007 SHALL have port shiftType, input, 1 bit: 1 = logical, 0 = arithmetic.
REQ-008 SHALL have port shiftOut, output, WIDTH bits: registered result.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; busy = (state != IDLE).
REQ-012 In IDLE with start=1 at edge E0: SHALL latch src into shiftOut, latch shiftType and direction sign, and load count = min(|shiftDirection|, WIDTH).
REQ-013 At accept: count>0 -> SHIFT; count=0 -> DONE.
REQ-014 In SHIFT: SHALL shift shiftOut by exactly one bit per clock and decrement count; the edge at which count goes 1->0 SHALL enter DONE.
REQ-015 Left shift: SHALL fill bit 0 with 0 for both shiftType values.
REQ-016 Right shift: SHALL fill MSB with 0 when shiftType=1, and with the current MSB when shiftType=0.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE, rising N edges after E0 (N = loaded count); DONE -> IDLE unconditionally.
REQ-018 start SHALL be ignored while busy=1; src/shiftDirection/shiftType changes after E0 SHALL NOT affect the operation in progress.
REQ-019 shiftOut SHALL hold its value between operations until the next accepted start.
REQ-020 shiftDirection = most-negative value (16'h8000 at WIDTH=16) SHALL saturate to count = WIDTH.
REQ-021 start asserted in the DONE cycle SHALL be ignored; start held high SHALL be accepted in the cycle after DONE (back-to-back ops, one idle cycle between).

Reset
REQ-022 reset_n=0 SHALL immediately, asynchronously force state=IDLE, shiftOut=0, count=0, busy=0, done=0, including mid-operation.
REQ-023 After reset_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-024 Macro SHIFTER_ROTATE_EN defined: SHALL add input port rotate (1 bit); rotate=1 overrides shiftType, rotates in the direction given by the sign of shiftDirection, with count = |shiftDirection| mod WIDTH.
REQ-025 Macro SHIFTER_ROTATE_EN undefined: port rotate SHALL NOT exist; behaviour is exactly REQ-011..REQ-021.

Verification
REQ-026 src=16'h0000, shiftDirection=16'h0000, shiftType=0, start pulse -> done rises at E0, shiftOut=16'h0000.
REQ-027 src=16'hFFFF, shiftDirection=16'hFFFF, shiftType=1 -> done rises at E1, shiftOut=16'h7FFF; same with shiftType=0 -> 16'hFFFF.
REQ-028 src=16'h8000, shiftDirection=16'hFFFC (-4), shiftType=0 -> done rises at E4, shiftOut=16'hF800; shiftDirection=16'h0001 -> shiftOut=16'h0000.
REQ-029 src=16'h1234, shiftDirection=16'h0014 (+20), shiftType=1 -> done rises at E16, shiftOut=16'h0000; start pulses during busy produce no extra done.
REQ-030 start at E0 with shiftDirection=16'h0008, reset_n pulsed low after E3 -> shiftOut=0, busy=0, done never asserted; new op after release completes correctly.
REQ-031 With SHIFTER_ROTATE_EN: src=16'h8001, shiftDirection=16'h0001, rotate=1 -> shiftOut=16'h0003 at E1; shiftDirection=16'h0010 -> done at E0, shiftOut=16'h8001.

Source files
------------

// File: rtl/shifter_seq.sv
// shifter_seq: sequential barrel-free shifter, one bit per clock; `SHIFTER_ROTATE_EN adds a rotate input.
// Latency: done pulses min(|shiftDirection|, WIDTH) edges after the accepting edge (0 -> next cycle).
// Backpressure: start is ignored while busy (SHIFT or DONE); held start re-accepts after one idle cycle.
module shifter_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] shiftDirection,
    input  logic             shiftType,
`ifdef SHIFTER_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] shiftOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             left_q, left_d;
    logic             logical_q, logical_d;
    logic             rot_q;

    logic [WIDTH-1:0] mag;
    logic [CW-1:0]    load_cnt;
    logic             right_fill;
    logic [WIDTH-1:0] step;

    // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign mag = shiftDirection[WIDTH-1] ? (~shiftDirection + 1'b1) : shiftDirection;

`ifdef SHIFTER_ROTATE_EN
    logic rot_d;

    always_comb begin
        if (rotate) begin
            load_cnt = CW'(mag % WIDTH_V);
        end else if (mag > WIDTH_V) begin
            load_cnt = CW'(WIDTH);
        end else begin
            load_cnt = mag[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rot_q <= 1'b0;
        end else begin
            rot_q <= rot_d;
        end
    end

    assign rot_d = (state_q == ST_IDLE && start) ? rotate : rot_q;
`else
    always_comb begin
        if (mag > WIDTH_V) begin
            load_cnt = CW'(WIDTH);
        end else begin
            load_cnt = mag[CW-1:0];
        end
    end

    assign rot_q = 1'b0;
`endif

    // Right-shift fill: wrapped LSB when rotating, else zero (logical) or sign (arithmetic).
    assign right_fill = rot_q ? out_q[0] : (logical_q ? 1'b0 : out_q[WIDTH-1]);

    always_comb begin
        if (left_q) begin
            step = {out_q[WIDTH-2:0], rot_q ? out_q[WIDTH-1] : 1'b0};
        end else begin
            step = {right_fill, out_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        left_d    = left_q;
        logical_d = logical_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    out_d     = src;
                    left_d    = ~shiftDirection[WIDTH-1];
                    logical_d = shiftType;
                    cnt_d     = load_cnt;
                    state_d   = (load_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                out_d = step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_q     <= '0;
            left_q    <= 1'b0;
            logical_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            left_q    <= left_d;
            logical_q <= logical_d;
        end
    end

    assign shiftOut = out_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: directed corner cases plus randomized ops against a shift-rule reference model.
module tb_shifter_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  src;
    logic [W-1:0]  sdir;
    logic          stype;
    logic [W-1:0]  shift_out;
    logic          busy;
    logic          done;
`ifdef SHIFTER_ROTATE_EN
    logic          rotate;
`endif

    int vectors     = 0;
    int miscompares = 0;

    shifter_seq #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .src            (src),
        .shiftDirection (sdir),
        .shiftType      (stype),
`ifdef SHIFTER_ROTATE_EN
        .rotate         (rotate),
`endif
        .shiftOut       (shift_out),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result and cycle count straight from the shift rules, no state machine.
    function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic [W-1:0] d,
                                           input logic t, input logic rot, output int n);
        int sd;
        int mag;
        logic signed [W-1:0] ss;
        sd  = int'($signed(d));
        mag = (sd < 0) ? -sd : sd;
        if (rot) begin
            n = mag % W;
            if (sd >= 0) return (s << n) | (s >> (W - n));
            return (s >> n) | (s << (W - n));
        end
        n = (mag > W) ? W : mag;
        if (sd >= 0) return s << n;
        if (t) return s >> n;
        ss = s;
        return ss >>> n;
    endfunction

    task automatic drive_rot(input logic r);
`ifdef SHIFTER_ROTATE_EN
        rotate = r;
`else
        if (r) $display("rotate request ignored in this build");
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] s, input logic [W-1:0] d,
                          input logic t, input logic rot, input bit poke);
        logic [W-1:0] exp;
        int n;
        int edges;
        bit seen;
        exp = model(s, d, t, rot, n);
        @(negedge clk);
        src = s; sdir = d; stype = t; drive_rot(rot); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src = W'($urandom); sdir = W'($urandom); stype = 1'($urandom);
        drive_rot(1'b0);
        check({tag, " busy_after_accept"}, busy, 1);
        edges = 0;
        seen  = 0;
        while (!seen && edges <= 40) begin
            start = 1'b0;
            if (done) begin
                seen = 1;
            end else begin
                if (poke && busy) start = 1'($urandom_range(0, 1));
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, edges, n);
        check({tag, " result"}, shift_out, exp);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " idle_after"}, busy, 0);
        src = W'($urandom);
        repeat (2) @(negedge clk);
        check({tag, " hold"}, shift_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_a, exp_b, o1, o2;
        int na, nb, e1, e2, nd, dcount;

        reset_n = 1'b0; start = 1'b0; src = '0; sdir = '0; stype = 1'b0;
        drive_rot(1'b0);
        #1;
        check("reset shiftOut", shift_out, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("zero_pass",   16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        run_op("neg1_logic",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
        run_op("neg1_arith",  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0);
        run_op("neg4_arith",  16'h8000, 16'hFFFC, 1'b0, 1'b0, 0);
        run_op("pos1_left",   16'h8000, 16'h0001, 1'b0, 1'b0, 0);
        run_op("pos20_sat",   16'h1234, 16'h0014, 1'b1, 1'b0, 1);
        run_op("minneg_sat",  16'h8001, 16'h8000, 1'b0, 1'b0, 1);
        run_op("minneg_log",  16'h8001, 16'h8000, 1'b1, 1'b0, 0);

        // Reset in the middle of an 8-step shift.
        @(negedge clk);
        src = W'($urandom); sdir = 16'h0008; stype = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midop busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midop_reset shiftOut", shift_out, 0);
        check("midop_reset busy", busy, 0);
        check("midop_reset done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midop_reset no_done", dcount, 0);
        run_op("after_reset", 16'h00FF, 16'hFFFE, 1'b1, 1'b0, 0);

        // Start held high across two operations.
        exp_a = model(16'h00F0, 16'h0002, 1'b1, 1'b0, na);
        exp_b = model(16'h0F0F, 16'hFFFD, 1'b0, 1'b0, nb);
        @(negedge clk);
        src = 16'h00F0; sdir = 16'h0002; stype = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        src = 16'h0F0F; sdir = 16'hFFFD; stype = 1'b0;
        nd = 0; e1 = -1; e2 = -1; o1 = '0; o2 = '0;
        for (int k = 1; k <= 20 && nd < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (nd == 0) begin
                    e1 = k; o1 = shift_out;
                end else begin
                    e2 = k; o2 = shift_out; start = 1'b0;
                end
                nd++;
            end
        end
        start = 1'b0;
        check("b2b first_edge", e1, na);
        check("b2b first_result", o1, exp_a);
        check("b2b second_edge", e2, na + 2 + nb);
        check("b2b second_result", o2, exp_b);
        @(negedge clk);
        check("b2b idle", busy, 0);

`ifdef SHIFTER_ROTATE_EN
        run_op("rot_left1",  16'h8001, 16'h0001, 1'b0, 1'b1, 0);
        run_op("rot_full",   16'h8001, 16'h0010, 1'b0, 1'b1, 0);
        run_op("rot_right3", 16'h8001, 16'hFFFD, 1'b1, 1'b1, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] rs, rd;
            rs = W'($urandom);
            rd = (i % 3 == 0) ? W'($urandom) : W'($urandom_range(0, 40) - 20);
            run_op($sformatf("rand%0d", i), rs, rd, 1'($urandom), 1'b0, bit'(i % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
